// File: rtl/vector_op_sched.sv
// vector_op_sched: queues four-operand jobs, runs each on one vector_op accelerator over Avalon-MM, streams back sum or timeout abort.
// Latency 9 cycles + accelerator run per job, +1 per waitrequest cycle; a held result blocks the next job while the FIFO keeps filling.

module vector_op_sched_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module vector_op_sched #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [127:0]             job_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic                     res_error,
  output logic [ADDRESS_WIDTH-1:0] m_address,
  output logic                     m_read,
  input  logic [31:0]              m_readdata,
  output logic                     m_write,
  output logic [31:0]              m_writedata,
  input  logic                     m_waitrequest,
  input  logic                     done_irq,
  output logic                     busy
);
  typedef struct packed {
    logic [31:0] op5;
    logic [31:0] op4;
    logic [31:0] op3;
    logic [31:0] op2;
  } job_t;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_CLEAR, S_OUT
  } state_t;

  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t         state_q, state_d;
  logic           live_q;
  logic [1:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  job_t           job_q, job_d;
  logic [127:0]   fifo_dat;
  logic [FCW-1:0] fifo_cnt;
  logic [31:0]    res_data_d;
  logic           res_error_d;
  logic           push;
  logic           pop;
  logic           xfer_ok;

  // live_q keeps the FIFO closed and the bus quiet until the first edge after reset
  assign job_ready = live_q && (fifo_cnt < FCW'(FIFO_DEPTH));
  assign push      = job_valid && job_ready;
  assign busy      = (state_q != S_IDLE) || (fifo_cnt != '0);
  assign res_valid = (state_q == S_OUT);
  assign xfer_ok   = !m_waitrequest;

  vector_op_sched_fifo #(.WIDTH(128), .DEPTH(FIFO_DEPTH)) u_job_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (job_data),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      live_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      job_q     <= '0;
      res_data  <= '0;
      res_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      job_q     <= job_d;
      res_data  <= res_data_d;
      res_error <= res_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    job_d       = job_q;
    res_data_d  = res_data;
    res_error_d = res_error;
    pop         = 1'b0;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    case (state_q)
      S_INIT: begin
        m_write = live_q;
        if (live_q && xfer_ok) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (fifo_cnt != '0) begin
          pop     = 1'b1;
          job_d   = fifo_dat;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        m_write   = 1'b1;
        m_address = ADDRESS_WIDTH'({1'b0, idx_q} + 3'd2);
        case (idx_q)
          2'd0:    m_writedata = job_q.op2;
          2'd1:    m_writedata = job_q.op3;
          2'd2:    m_writedata = job_q.op4;
          default: m_writedata = job_q.op5;
        endcase
        if (xfer_ok) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'd3) state_d = S_START;
        end
      end
      S_START: begin
        m_write     = 1'b1;
        m_writedata = 32'd1;
        if (xfer_ok) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done_irq is checked first so a completion on the final cycle still wins
        cnt_d = cnt_q + 1'b1;
        if (done_irq) begin
          state_d = S_READ;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          res_data_d  = '1;
          res_error_d = 1'b1;
          state_d     = S_CLEAR;
        end
      end
      S_READ: begin
        m_read    = 1'b1;
        m_address = ADDRESS_WIDTH'(1);
        if (xfer_ok) begin
          res_data_d  = m_readdata;
          res_error_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        m_write = 1'b1;
        if (xfer_ok) state_d = S_OUT;
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_vector_op_sched.sv
// Directed bench for vector_op_sched with a behavioural vector_op accelerator on the Avalon side.
module tb_vector_op_sched;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [127:0]  job_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic          res_error;
  logic [AW-1:0] m_address;
  logic          m_read;
  logic [31:0]   m_readdata;
  logic          m_write;
  logic [31:0]   m_writedata;
  logic          m_waitrequest = 1'b0;
  logic          done_irq;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vector_op_sched #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(300)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .done_irq(done_irq), .busy(busy)
  );

  // accelerator model and transfer log
  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] data;
    int          stamp;
  } xfer_t;

  xfer_t       log_q[$];
  logic [31:0] acc_regs [8];
  logic [31:0] acc_result = '0;
  bit          acc_active = 0;
  int          acc_cnt = 0;
  int          done_delay = 257;
  bit          never_done = 0;
  bit          stall_en = 0;
  bit          stall_pend = 0;
  logic [36:0] stall_snap = '0;
  int          stall_viol = 0;
  int          stall_seen = 0;
  int          both_viol = 0;
  int          cyc = 0;

  assign done_irq   = acc_active && !never_done && (acc_cnt >= done_delay);
  assign m_readdata = (m_address == 3'd1) ? acc_result : acc_regs[m_address];

  always @(negedge clk) begin
    m_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    #1;
    cyc++;
    if (acc_active) acc_cnt++;
    if (!rst) begin
      if (m_read && m_write) both_viol++;
      if (stall_pend) begin
        if ({m_read, m_write, m_address, m_writedata} !== stall_snap) stall_viol++;
        stall_pend = 0;
      end
      if ((m_read || m_write) && m_waitrequest) begin
        stall_pend = 1;
        stall_snap = {m_read, m_write, m_address, m_writedata};
        stall_seen++;
      end else if (m_write) begin
        log_q.push_back('{1'b1, int'(m_address), m_writedata, cyc});
        acc_regs[m_address] = m_writedata;
        if (m_address == 3'd0) begin
          if (m_writedata[0]) begin
            acc_result = acc_regs[2] + acc_regs[3] + acc_regs[4] + acc_regs[5];
            acc_active = 1;
            acc_cnt    = 0;
          end else begin
            acc_active = 0;
          end
        end
      end else if (m_read) begin
        log_q.push_back('{1'b0, int'(m_address), m_readdata, cyc});
      end
    end else begin
      stall_pend = 0;
    end
  end

  task automatic push_job(input logic [127:0] d, output bit ok);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      job_valid = 1'b1;
      job_data  = d;
      if (job_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_res(input int budget, output bit ok, output int cycles);
    ok = 0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pop_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #22;
    vectors++;
    if ({job_ready, res_valid, res_error, m_read, m_write, busy} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 000001", {job_ready, res_valid, res_error, m_read, m_write, busy});
    end
    vectors++;
    if (res_data !== 32'd0 || m_writedata !== 32'd0 || m_address !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_data: got res_data=%h wdata=%h addr=%0d, expected all zero", res_data, m_writedata, m_address);
    end
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (job_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b, expected 1", job_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (log_q.size() != 1) begin
      miscompares++;
      $display("FAIL init_xfer_count: got %0d, expected 1", log_q.size());
    end else if (!(log_q[0].wr && log_q[0].addr == 0 && log_q[0].data === 32'd0)) begin
      miscompares++;
      $display("FAIL init_xfer: got wr=%0d %0d:%h, expected write 0:0", log_q[0].wr, log_q[0].addr, log_q[0].data);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_single_job(input bit with_stall, input string tag);
    bit ok;
    int n;
    bit          ew[7] = '{1, 1, 1, 1, 1, 0, 1};
    int          ea[7] = '{2, 3, 4, 5, 0, 1, 0};
    logic [31:0] ed[7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd10, 32'd0};
    log_q.delete();
    stall_seen = 0;
    stall_viol = 0;
    both_viol  = 0;
    stall_en   = with_stall;
    push_job({32'd4, 32'd3, 32'd2, 32'd1}, ok);
    @(negedge clk);
    job_valid = 1'b0;
    wait_res(1000, ok, n);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s result_timeout: got no res_valid within %0d cycles, expected one", tag, n);
    end
    if (!with_stall) begin
      vectors++;
      if (n != 265) begin
        miscompares++;
        $display("FAIL %s latency: got %0d, expected 265", tag, n);
      end
    end
    vectors++;
    if (res_data !== 32'd10 || res_error !== 1'b0) begin
      miscompares++;
      $display("FAIL %s result: got %h err=%b, expected 0000000a err=0", tag, res_data, res_error);
    end
    vectors++;
    if (log_q.size() != 7) begin
      miscompares++;
      $display("FAIL %s xfer_count: got %0d, expected 7", tag, log_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (log_q[i].wr != ew[i] || log_q[i].addr != ea[i] || log_q[i].data !== ed[i]) begin
          miscompares++;
          $display("FAIL %s xfer%0d: got wr=%0d %0d:%h, expected wr=%0d %0d:%h", tag, i,
                   log_q[i].wr, log_q[i].addr, log_q[i].data, ew[i], ea[i], ed[i]);
        end
      end
    end
    if (with_stall) begin
      vectors++;
      if (stall_seen == 0 || stall_viol != 0) begin
        miscompares++;
        $display("FAIL %s stall_hold: got seen=%0d unstable=%0d, expected seen>0 unstable=0", tag, stall_seen, stall_viol);
      end
    end
    vectors++;
    if (both_viol != 0) begin
      miscompares++;
      $display("FAIL %s rd_wr_overlap: got %0d, expected 0", tag, both_viol);
    end
    pop_res();
    stall_en = 0;
  endtask

  task automatic test_wrap();
    bit ok;
    int n;
    push_job({32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, ok);
    @(negedge clk);
    job_valid = 1'b0;
    wait_res(600, ok, n);
    vectors++;
    if (!ok || res_data !== 32'd0 || res_error !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: got valid=%b %h err=%b, expected valid=1 00000000 err=0", ok, res_data, res_error);
    end
    pop_res();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int hold_bad;
    logic [31:0] exp;
    for (int i = 1; i <= 5; i++) begin
      push_job({32'd100, 32'(3 * i), 32'(2 * i), 32'(i)}, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL b2b_push%0d: got not accepted, expected accepted", i);
      end
    end
    #1;
    vectors++;
    if (job_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full: got job_ready=%b, expected 0", job_ready);
    end
    @(negedge clk);
    job_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp = 32'(6 * i + 100);
      wait_res(600, ok, n);
      vectors++;
      if (!ok || res_data !== exp || res_error !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_result%0d: got valid=%b %0d err=%b, expected valid=1 %0d err=0", i, ok, res_data, res_error, exp);
      end
      if (i == 1) begin
        hold_bad = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (res_valid !== 1'b1 || res_data !== exp || job_ready !== 1'b0) hold_bad++;
        end
        vectors++;
        if (hold_bad != 0) begin
          miscompares++;
          $display("FAIL b2b_hold: got %0d unstable cycles, expected 0", hold_bad);
        end
      end
      pop_res();
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    never_done = 1;
    log_q.delete();
    push_job({32'd4, 32'd3, 32'd2, 32'd1}, ok);
    @(negedge clk);
    job_valid = 1'b0;
    wait_res(800, ok, n);
    vectors++;
    if (!ok || res_data !== 32'hFFFF_FFFF || res_error !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_result: got valid=%b %h err=%b, expected valid=1 ffffffff err=1", ok, res_data, res_error);
    end
    vectors++;
    if (log_q.size() != 6) begin
      miscompares++;
      $display("FAIL timeout_xfer_count: got %0d, expected 6", log_q.size());
    end else begin
      vectors++;
      if (!(log_q[5].wr && log_q[5].addr == 0 && log_q[5].data === 32'd0)) begin
        miscompares++;
        $display("FAIL timeout_clear: got wr=%0d %0d:%h, expected write 0:0", log_q[5].wr, log_q[5].addr, log_q[5].data);
      end
      vectors++;
      if (log_q[5].stamp - log_q[4].stamp != 301) begin
        miscompares++;
        $display("FAIL timeout_wait_cycles: got %0d, expected 300", log_q[5].stamp - log_q[4].stamp - 1);
      end
    end
    pop_res();
    never_done = 0;
  endtask

  task automatic test_done_tie();
    bit ok;
    int n;
    int          dl[2] = '{300, 301};
    bit          ee[2] = '{0, 1};
    logic [31:0] er[2] = '{32'd10, 32'hFFFF_FFFF};
    for (int k = 0; k < 2; k++) begin
      done_delay = dl[k];
      push_job({32'd4, 32'd3, 32'd2, 32'd1}, ok);
      @(negedge clk);
      job_valid = 1'b0;
      wait_res(800, ok, n);
      vectors++;
      if (!ok || res_data !== er[k] || res_error !== ee[k]) begin
        miscompares++;
        $display("FAIL done_at_%0d: got valid=%b %h err=%b, expected valid=1 %h err=%0d", dl[k], ok, res_data, res_error, er[k], ee[k]);
      end
      pop_res();
    end
    done_delay = 257;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    log_q.delete();
    push_job({32'd4, 32'd3, 32'd2, 32'd1}, ok);
    push_job({32'd5, 32'd5, 32'd5, 32'd5}, ok);
    @(negedge clk);
    job_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (log_q.size() >= 5) begin
        ok = 1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_start: got %0d transfers, expected start write", log_q.size());
    end
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    vectors++;
    if ({job_ready, res_valid, res_error, m_read, m_write, busy} !== 6'b000001 ||
        res_data !== 32'd0 || m_address !== 3'd0 || m_writedata !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got flags=%b data=%h addr=%0d wdata=%h, expected 000001 and zeros",
               {job_ready, res_valid, res_error, m_read, m_write, busy}, res_data, m_address, m_writedata);
    end
    repeat (3) @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (log_q.size() < 1 || !(log_q[0].wr && log_q[0].addr == 0 && log_q[0].data === 32'd0)) begin
      miscompares++;
      $display("FAIL midrst_first_xfer: got %0d transfers, expected first write 0:0", log_q.size());
    end
    vectors++;
    if (busy !== 1'b0 || job_ready !== 1'b1 || log_q.size() != 1) begin
      miscompares++;
      $display("FAIL midrst_fifo_empty: got busy=%b ready=%b xfers=%0d, expected 0 1 1", busy, job_ready, log_q.size());
    end
    seen = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midrst_no_result: got %0d valid cycles, expected 0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) acc_regs[i] = '0;
    test_reset();
    test_single_job(0, "single");
    test_wrap();
    test_back_to_back();
    test_single_job(1, "waitreq");
    test_timeout();
    test_single_job(0, "after_timeout");
    test_done_tie();
    test_reset_mid();
    test_single_job(0, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
